// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel edge-detection pipeline.
// Every block in the pipeline takes its parameter defaults from here.
package sobel_pkg;

  localparam int SOBEL_MAX_W    = 1920;
  localparam int SOBEL_DW       = 8;
  localparam int SOBEL_NLINES   = 2;

endpackage

// File: rtl/dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Reads are read-first; contents are never reset.
module dp_ram #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/multi_line_delay.sv
// Line-delay cascade for a Sobel window: current pixel plus the
// same column from NUM_LINES earlier rows, zero-padded at the top.
module multi_line_delay
  import sobel_pkg::*;
#(
  parameter  int MAX_LINE_WIDTH = SOBEL_MAX_W,
  parameter  int DATA_WIDTH     = SOBEL_DW,
  parameter  int NUM_LINES      = SOBEL_NLINES,
  localparam int AW             = $clog2(MAX_LINE_WIDTH),
  localparam int LW             = $clog2(MAX_LINE_WIDTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [LW-1:0]                   line_width,
  input  logic                            sof,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic                            data_valid,
  output logic [DATA_WIDTH-1:0]           cur_out,
  output logic [NUM_LINES*DATA_WIDTH-1:0] taps_out,
  output logic [AW-1:0]                   col_out,
  output logic                            out_valid,
  output logic                            primed
);

  localparam int LCW = $clog2(NUM_LINES + 1);

  logic [LW-1:0]         aw_q, aw_d, lw_clamp, w_cur;
  logic [AW-1:0]         col_q, col_d, col_cur, colo_q;
  logic [LCW-1:0]        lcnt_q, lcnt_d, lcnt_cur, plcnt_q;
  logic                  sofv, wrap, ov_q;
  logic [DATA_WIDTH-1:0] cur_q;
  logic [DATA_WIDTH-1:0] rd [NUM_LINES];
  logic [DATA_WIDTH-1:0] wd [NUM_LINES];

  always_comb begin
    lw_clamp = line_width;
    if (line_width < LW'(2))
      lw_clamp = LW'(2);
    else if (line_width > LW'(MAX_LINE_WIDTH))
      lw_clamp = LW'(MAX_LINE_WIDTH);
  end

  // A qualified sof restarts the frame on this very pixel.
  always_comb begin
    sofv     = sof && data_valid;
    col_cur  = sofv ? '0 : col_q;
    lcnt_cur = sofv ? '0 : lcnt_q;
    w_cur    = sofv ? lw_clamp : aw_q;
    wrap     = (LW'(col_cur) == w_cur - LW'(1));
    aw_d     = w_cur;
    col_d    = col_q;
    lcnt_d   = lcnt_q;
    if (data_valid) begin
      col_d  = wrap ? '0 : col_cur + AW'(1);
      lcnt_d = lcnt_cur;
      if (wrap && lcnt_cur != LCW'(NUM_LINES))
        lcnt_d = lcnt_cur + LCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      aw_q    <= lw_clamp;
      col_q   <= '0;
      lcnt_q  <= '0;
      ov_q    <= 1'b0;
      cur_q   <= '0;
      colo_q  <= '0;
      plcnt_q <= '0;
    end else begin
      aw_q   <= aw_d;
      col_q  <= col_d;
      lcnt_q <= lcnt_d;
      ov_q   <= data_valid;
      if (data_valid) begin
        cur_q   <= data_in;
        colo_q  <= col_cur;
        plcnt_q <= lcnt_cur;
      end
    end
  end

  for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
    if (k == 0) begin : g_head
      assign wd[k] = cur_q;
    end else begin : g_tail
      assign wd[k] = rd[k-1];
    end

    dp_ram #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (MAX_LINE_WIDTH)
    ) u_ram (
      .clk     (clk),
      .we_i    (ov_q),
      .waddr_i (colo_q),
      .wdata_i (wd[k]),
      .re_i    (data_valid),
      .raddr_i (col_cur),
      .rdata_o (rd[k])
    );

    // Rows above the frame top read as zero, hiding stale RAM data.
    assign taps_out[k*DATA_WIDTH +: DATA_WIDTH] =
      (plcnt_q > LCW'(k)) ? rd[k] : '0;
  end

  assign cur_out   = cur_q;
  assign col_out   = colo_q;
  assign out_valid = ov_q;
  assign primed    = ov_q && (plcnt_q == LCW'(NUM_LINES));

endmodule

// File: tb/tb_multi_line_delay.sv
// Directed bench for multi_line_delay with a row-history reference
// model feeding an expected-output queue.
module tb_multi_line_delay;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] line_width;
  logic        sof;
  logic [7:0]  data_in;
  logic        data_valid;
  logic [7:0]  cur_out;
  logic [15:0] taps_out;
  logic [10:0] col_out;
  logic        out_valid;
  logic        primed;

  typedef struct {
    logic [7:0]  cur;
    logic [10:0] col;
    logic [15:0] taps;
    logic        primed;
  } exp_t;

  exp_t        q [$];
  logic [7:0]  frame [longint];
  int          m_col, m_row, m_w;
  int unsigned nvec = 0;
  int unsigned nerr = 0;
  logic        exp_ov = 1'b0;

  multi_line_delay dut (
    .clk        (clk),
    .rst        (rst),
    .line_width (line_width),
    .sof        (sof),
    .data_in    (data_in),
    .data_valid (data_valid),
    .cur_out    (cur_out),
    .taps_out   (taps_out),
    .col_out    (col_out),
    .out_valid  (out_valid),
    .primed     (primed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampw(input int lw);
    if (lw < 2) return 2;
    if (lw > 1920) return 1920;
    return lw;
  endfunction

  function automatic longint key(input int r, input int c);
    return longint'(r) * 4096 + longint'(c);
  endfunction

  task automatic model_restart(input int lw);
    m_w = clampw(lw);
    m_col = 0;
    m_row = 0;
    frame.delete();
  endtask

  task automatic drive(input logic s, input logic [7:0] d,
                       input logic v, input int lw);
    exp_t e;
    sof = s;
    data_in = d;
    data_valid = v;
    line_width = lw[10:0];
    if (v) begin
      if (s) model_restart(lw);
      e.cur = d;
      e.col = m_col[10:0];
      e.taps = '0;
      for (int k = 0; k < 2; k++)
        if (m_row > k && frame.exists(key(m_row - k - 1, m_col)))
          e.taps[k*8 +: 8] = frame[key(m_row - k - 1, m_col)];
      e.primed = (m_row >= 2);
      frame[key(m_row, m_col)] = d;
      q.push_back(e);
      if (m_col == m_w - 1) begin
        m_col = 0;
        m_row++;
      end else begin
        m_col++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ov"}, out_valid, 0);
    chk({tag, "_cur"}, cur_out, 0);
    chk({tag, "_col"}, col_out, 0);
    chk({tag, "_taps"}, taps_out, 0);
    chk({tag, "_primed"}, primed, 0);
  endtask

  always @(posedge clk) exp_ov <= rst && data_valid;

  always @(negedge clk) begin
    exp_t e;
    chk("out_valid", out_valid, exp_ov);
    if (out_valid) begin
      chk("pending_exp", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("cur_out", cur_out, e.cur);
        chk("col_out", col_out, e.col);
        chk("taps_out", taps_out, e.taps);
        chk("primed", primed, e.primed);
      end
    end else begin
      chk("primed_idle", primed, 0);
    end
  end

  initial begin
    int n;
    rst = 1'b0;
    sof = 1'b0;
    data_in = '0;
    data_valid = 1'b0;
    line_width = 11'd4;
    model_restart(4);
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;

    for (int i = 1; i <= 12; i++) begin
      drive(i == 1, 8'(i), 1'b1, 4);
      if (i == 9) begin
        chk("p9_cur", cur_out, 9);
        chk("p9_col", col_out, 0);
        chk("p9_taps", taps_out, 16'h0105);
        chk("p9_primed", primed, 1);
      end
    end

    for (int i = 1; i <= 12; i++) begin
      drive(i == 1, 8'(i + 64), 1'b1, 4);
      drive(1'b0, 8'hEE, 1'b0, 4);
      chk("gap_ov", out_valid, 0);
    end

    drive(1'b1, 8'd20, 1'b1, 4);
    drive(1'b0, 8'd21, 1'b1, 4);
    drive(1'b1, 8'd22, 1'b1, 3);
    chk("midsof_col", col_out, 0);
    chk("midsof_taps", taps_out, 0);
    chk("midsof_primed", primed, 0);
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 8'(23 + i), 1'b1, 7);
      if (i == 2) chk("w3_wrap_col", col_out, 0);
    end

    for (int i = 0; i < 6; i++) begin
      drive(i == 0, 8'(40 + i), 1'b1, 0);
      if (i == 2) chk("w0_col", col_out, 0);
    end
    for (int i = 0; i < 6; i++) begin
      drive(i == 0, 8'(50 + i), 1'b1, 1);
      if (i == 2) chk("w1_col", col_out, 0);
    end

    drive(1'b1, 8'd1, 1'b1, 4);
    for (int i = 2; i <= 13; i++) drive(1'b0, 8'(i), 1'b1, 4);
    rst = 1'b0;
    data_valid = 1'b0;
    sof = 1'b0;
    model_restart(4);
    @(posedge clk);
    #1;
    check_zero("midrst");
    rst = 1'b1;
    drive(1'b0, 8'h77, 1'b1, 4);
    chk("postrst_col", col_out, 0);
    chk("postrst_taps", taps_out, 0);
    chk("postrst_primed", primed, 0);
    for (int i = 0; i < 10; i++) drive(1'b0, 8'(128 + i), 1'b1, 4);

    n = 0;
    drive(1'b1, 8'($urandom_range(0, 255)), 1'b1, 2047);
    n++;
    while (n < 4 * 1920) begin
      if ($urandom_range(0, 15) == 0)
        drive(1'b0, 8'h00, 1'b0, 2047);
      drive(1'b0, 8'($urandom_range(0, 255)), 1'b1, 2047);
      n++;
      if (n == 1920) chk("wmax_lastcol", col_out, 1919);
      if (n == 1921) chk("wmax_wrap", col_out, 0);
    end

    repeat (3) drive(1'b0, 8'h00, 1'b0, 4);
    chk("scoreboard_drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
